// File: rtl/acc_core_mc.sv
// rtl/acc_core_mc.sv - multicycle accumulator core with a stallable req/ack data port
// Optional memory watchdog halt: define ACC_CORE_MC_TIMEOUT_EN.
module acc_core_mc #(
  parameter int DW   = 8,
  parameter int NREG = 16,
  parameter int IW   = 9,
  parameter int PCW  = 16
) (
  input  logic           clk,
  input  logic           reset,
  output logic [PCW-1:0] pc,
  input  logic [IW-1:0]  inst,
  output logic           dm_req,
  output logic           dm_we,
  output logic [DW-1:0]  dm_addr,
  output logic [DW-1:0]  dm_wdata,
  input  logic [DW-1:0]  dm_rdata,
  input  logic           dm_ack,
  output logic           done,
  output logic           err
);

  localparam int FW = IW - 4;
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [3:0] OP_LDI = 4'h0, OP_LDR = 4'h1, OP_STR = 4'h2, OP_ADD = 4'h3;
  localparam logic [3:0] OP_ADC = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8, OP_SHL = 4'h9, OP_MLD = 4'hA, OP_MST = 4'hB;
  localparam logic [3:0] OP_BRZ = 4'hC, OP_BRN = 4'hD, OP_JMP = 4'hE, OP_HALT = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  state_t state, state_nx;

  logic [IW-1:0]  ir;
  logic [DW-1:0]  acc;
  logic           z, n, c;
  logic [DW-1:0]  regs [NREG];

  logic [3:0]     op;
  logic [FW-1:0]  f;
  logic [RW-1:0]  ridx;
  logic [DW-1:0]  rv;
  logic [DW-1:0]  imm;
  logic [PCW-1:0] offset;
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] pc_nx;
  logic           taken;
  logic           is_mem;

  logic [DW-1:0]  alu;
  logic           alu_c;
  logic           acc_we;
  logic           c_we;
  logic [DW:0]    sum;
  logic           tout;

  assign op     = ir[IW-1:IW-4];
  assign f      = ir[FW-1:0];
  assign ridx   = f[RW-1:0];
  assign rv     = regs[ridx];
  assign imm    = DW'(f);
  assign offset = {{(PCW-FW){f[FW-1]}}, f};
  assign pc_inc = pc + {{(PCW-1){1'b0}}, 1'b1};
  assign is_mem = (op == OP_MLD) || (op == OP_MST);

  assign dm_req = (state == S_MEM);
  assign done   = (state == S_HALT) && !err;

`ifdef ACC_CORE_MC_TIMEOUT_EN
  logic [3:0] wcnt;
  logic       err_q;

  // Fires on the 16th consecutive unacknowledged MEM cycle; an ack in that cycle wins.
  assign tout = (state == S_MEM) && !dm_ack && (wcnt == 4'hF);
  assign err  = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt  <= 4'h0;
      err_q <= 1'b0;
    end else begin
      if (state == S_EXEC)
        wcnt <= 4'h0;
      else if (state == S_MEM && !dm_ack)
        wcnt <= wcnt + 4'h1;
      if (tout)
        err_q <= 1'b1;
    end
  end
`else
  assign tout = 1'b0;
  assign err  = 1'b0;
`endif

  always_comb begin
    alu    = acc;
    alu_c  = c;
    acc_we = 1'b0;
    c_we   = 1'b0;
    sum    = {1'b0, acc} + {1'b0, rv} + {{DW{1'b0}}, (op == OP_ADC) ? c : 1'b0};
    case (op)
      OP_LDI: begin alu = imm; acc_we = 1'b1; end
      OP_LDR: begin alu = rv;  acc_we = 1'b1; end
      OP_ADD, OP_ADC: begin
        alu = sum[DW-1:0]; alu_c = sum[DW]; acc_we = 1'b1; c_we = 1'b1;
      end
      OP_SUB: begin
        alu = acc - rv; alu_c = (acc >= rv); acc_we = 1'b1; c_we = 1'b1;
      end
      OP_AND: begin alu = acc & rv; acc_we = 1'b1; end
      OP_OR:  begin alu = acc | rv; acc_we = 1'b1; end
      OP_XOR: begin alu = acc ^ rv; acc_we = 1'b1; end
      OP_SHL: begin
        alu = {acc[DW-2:0], 1'b0}; alu_c = acc[DW-1]; acc_we = 1'b1; c_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    taken = (op == OP_JMP) || (op == OP_BRZ && z) || (op == OP_BRN && n);
    pc_nx = taken ? (pc + offset) : pc_inc;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH: state_nx = S_EXEC;
      S_EXEC: begin
        if (is_mem)
          state_nx = S_MEM;
        else if (op == OP_HALT)
          state_nx = S_HALT;
        else
          state_nx = S_FETCH;
      end
      S_MEM: begin
        if (dm_ack)
          state_nx = S_FETCH;
        else if (tout)
          state_nx = S_HALT;
      end
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_FETCH;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      ir       <= '0;
      acc      <= '0;
      z        <= 1'b1;
      n        <= 1'b0;
      c        <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: ir <= inst;
        S_EXEC: begin
          if (acc_we) begin
            acc <= alu;
            z   <= (alu == '0);
            n   <= alu[DW-1];
          end
          if (c_we)
            c <= alu_c;
          if (op == OP_STR)
            regs[ridx] <= acc;
          // Request fields are latched once so they stay stable for the whole MEM wait.
          if (is_mem) begin
            dm_addr  <= rv;
            dm_wdata <= acc;
            dm_we    <= (op == OP_MST);
          end else if (op != OP_HALT) begin
            pc <= pc_nx;
          end
        end
        S_MEM: begin
          if (dm_ack) begin
            if (!dm_we) begin
              acc <= dm_rdata;
              z   <= (dm_rdata == '0);
              n   <= dm_rdata[DW-1];
            end
            pc <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_core_mc.sv
// tb/tb_acc_core_mc.sv - self-checking bench for acc_core_mc: vector table, directed corners, random programs vs ISA model
// Timeout expectations follow ACC_CORE_MC_TIMEOUT_EN.
module tb_acc_core_mc;

  localparam int LDI = 0, LDR = 1, STR = 2, ADD = 3, ADC = 4, SUB = 5, AND = 6, OR = 7;
  localparam int XOR = 8, SHL = 9, MLD = 10, MST = 11, BRZ = 12, BRN = 13, JMP = 14, HLT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [8:0]  inst;
  logic        dm_req, dm_we, dm_ack, done, err;
  logic [7:0]  dm_addr, dm_wdata, dm_rdata;

  acc_core_mc #(.DW(8), .NREG(16), .IW(9), .PCW(16)) dut (
    .clk(clk), .reset(reset), .pc(pc), .inst(inst),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [8:0] imem [256];
  assign inst = imem[pc[7:0]];

  int n_tests = 0;
  int n_fail  = 0;

  int         ack_delay;
  bit         force_ack;
  bit         mem_wr_en;
  int         cur_gen;
  logic [7:0] dmem [256];

  logic [7:0] wmem [256];
  int         wgen [256];
  logic [7:0] q_st_addr [$];
  logic [7:0] q_st_data [$];
  int         q_len [$];
  bit         q_stable [$];

  logic [7:0] mdm [256];
  int         e_addr [$];
  int         e_data [$];

  typedef struct {
    logic [15:0][8:0] prog;
    int len, d, cyc, fpc, nst;
    int st [3];
  } vec_t;
  vec_t tv [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(input int op, input int f);
    logic [8:0] x;
    x = {op[3:0], f[4:0]};
    return x;
  endfunction

  // Data-memory responder: acks after ack_delay MEM cycles (0 = never), logs every transaction.
  initial begin
    int wc;
    logic [7:0] a0, w0;
    logic we0;
    bit stab;
    wc = 0; stab = 1'b1; a0 = '0; w0 = '0; we0 = 1'b0;
    dm_ack = 1'b0; dm_rdata = '0;
    forever begin
      @(negedge clk);
      if (dm_req === 1'b1) begin
        if (wc == 0) begin
          a0 = dm_addr; w0 = dm_wdata; we0 = dm_we; stab = 1'b1;
        end else if (dm_addr !== a0 || dm_wdata !== w0 || dm_we !== we0) begin
          stab = 1'b0;
        end
        wc++;
        dm_rdata = (wgen[dm_addr] == cur_gen) ? wmem[dm_addr] : dmem[dm_addr];
        dm_ack = force_ack || (ack_delay > 0 && wc >= ack_delay);
        if (dm_ack) begin
          q_len.push_back(wc);
          q_stable.push_back(stab);
          if (dm_we) begin
            q_st_addr.push_back(dm_addr);
            q_st_data.push_back(dm_wdata);
            if (mem_wr_en) begin
              wmem[dm_addr] = dm_wdata;
              wgen[dm_addr] = cur_gen;
            end
          end
          wc = 0;
        end
      end else begin
        dm_ack = force_ack;
        wc = 0;
      end
    end
  end

  // Instruction-level model: each instruction costs 2 cycles, memory ops d more.
  task automatic model(input int d, output int cyc, output int fpc);
    int acc, z, n, c, pcv, op, f, ri, rv, t, off;
    int r [16];
    acc = 0; z = 1; n = 0; c = 0; pcv = 0; cyc = 0;
    for (int i = 0; i < 16; i++) r[i] = 0;
    e_addr.delete(); e_data.delete();
    for (int step = 0; step < 1000; step++) begin
      op = int'(imem[pcv % 256]) / 32;
      f  = int'(imem[pcv % 256]) % 32;
      ri = f % 16;
      rv = r[ri];
      cyc += 2;
      if (op == HLT) break;
      if (op >= BRZ) begin
        off = (f >= 16) ? f - 32 : f;
        if (op == JMP || (op == BRZ && z != 0) || (op == BRN && n != 0))
          pcv = (pcv + off) & 16'hFFFF;
        else
          pcv = (pcv + 1) & 16'hFFFF;
        continue;
      end
      t = -1;
      case (op)
        LDI: t = f;
        LDR: t = rv;
        STR: r[ri] = acc;
        ADD: begin t = acc + rv; c = t / 256; end
        ADC: begin t = acc + rv + c; c = t / 256; end
        SUB: begin c = (acc >= rv) ? 1 : 0; t = (acc - rv + 256) % 256; end
        AND: t = acc & rv;
        OR:  t = acc | rv;
        XOR: t = acc ^ rv;
        SHL: begin c = acc / 128; t = (acc * 2) % 256; end
        MLD: begin cyc += d; t = int'(mdm[rv]); end
        MST: begin cyc += d; mdm[rv] = 8'(acc); e_addr.push_back(rv); e_data.push_back(acc); end
        default: ;
      endcase
      if (t >= 0) begin
        acc = t % 256;
        z = (acc == 0) ? 1 : 0;
        n = acc / 128;
      end
      pcv = (pcv + 1) & 16'hFFFF;
    end
    fpc = pcv;
  endtask

  task automatic run_dut(input int d, output int cyc, output int fpc);
    ack_delay = d;
    force_ack = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (done === 1'b1) break;
    end
    fpc = int'(pc);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = enc(HLT, 0);
  endtask

  task automatic vadd(input int v, input int op, input int f);
    tv[v].prog[tv[v].len] = enc(op, f);
    tv[v].len++;
  endtask

  // Tail exposes acc (first MST) and c (ADC of zeros into a cleared acc) at address 0.
  task automatic vend(input int v, input int d, input int cyc, input int fpc, input int s0, input int s1);
    vadd(v, MST, 15); vadd(v, LDI, 0); vadd(v, ADC, 14); vadd(v, MST, 15); vadd(v, HLT, 0);
    tv[v].d = d; tv[v].cyc = cyc; tv[v].fpc = fpc; tv[v].nst = 2;
    tv[v].st[0] = s0; tv[v].st[1] = s1; tv[v].st[2] = 0;
  endtask

  initial begin
    int cyc, fpc, ecyc, efpc, sb, lb, ng, cnt;
    bit allst;

    reset = 1'b1; force_ack = 1'b0; ack_delay = 1; mem_wr_en = 1'b1; cur_gen = 0;
    for (int i = 0; i < 256; i++) begin dmem[i] = '0; wmem[i] = '0; wgen[i] = 0; end
    clear_imem();
    for (int v = 0; v < 15; v++) tv[v].len = 0;

    vadd(0, LDI, 5); vadd(0, STR, 2); vadd(0, LDI, 3); vadd(0, ADD, 2); vend(0, 1, 20, 8, 8'h08, 0);
    vadd(1, LDI, 31); vadd(1, SHL, 0); vadd(1, SHL, 0); vadd(1, SHL, 0); vend(1, 1, 20, 8, 8'hF8, 0);
    vadd(2, LDI, 15); vadd(2, STR, 3); vadd(2, LDI, 31); vadd(2, SHL, 0); vadd(2, SHL, 0); vadd(2, SHL, 0);
    vadd(2, ADD, 3); vend(2, 1, 26, 11, 8'h07, 1);
    vadd(3, LDI, 15); vadd(3, STR, 3); vadd(3, LDI, 31); vadd(3, SHL, 0); vadd(3, SHL, 0); vadd(3, SHL, 0);
    vadd(3, ADD, 3); vadd(3, ADC, 4); vend(3, 1, 28, 12, 8'h08, 0);
    vadd(4, LDI, 1); vadd(4, STR, 5); vadd(4, LDI, 0); vadd(4, SUB, 5); vend(4, 1, 20, 8, 8'hFF, 0);
    vadd(5, LDI, 3); vadd(5, STR, 5); vadd(5, LDI, 7); vadd(5, SUB, 5); vend(5, 1, 20, 8, 8'h04, 1);
    vadd(6, LDI, 28); vadd(6, STR, 6); vadd(6, LDI, 21); vadd(6, AND, 6); vend(6, 1, 20, 8, 8'h14, 0);
    vadd(7, LDI, 28); vadd(7, STR, 6); vadd(7, LDI, 21); vadd(7, OR, 6); vend(7, 1, 20, 8, 8'h1D, 0);
    vadd(8, LDI, 28); vadd(8, STR, 6); vadd(8, LDI, 21); vadd(8, XOR, 6); vend(8, 1, 20, 8, 8'h09, 0);
    vadd(9, LDI, 0); vadd(9, BRZ, 2); vadd(9, LDI, 9); vadd(9, SHL, 0); vend(9, 1, 18, 8, 8'h00, 0);
    vadd(10, LDI, 1); vadd(10, BRZ, 2); vadd(10, LDI, 9); vadd(10, SHL, 0); vend(10, 1, 20, 8, 8'h12, 0);
    vadd(11, LDI, 1); vadd(11, STR, 5); vadd(11, LDI, 0); vadd(11, SUB, 5); vadd(11, BRN, 2); vadd(11, LDI, 9);
    vadd(11, SHL, 0); vend(11, 1, 24, 11, 8'hFE, 1);
    vadd(12, JMP, 3); vadd(12, LDI, 7); vadd(12, JMP, 5); vadd(12, LDI, 0); vadd(12, BRZ, 29); vadd(12, LDI, 31);
    vadd(12, LDI, 31); vend(12, 1, 22, 11, 8'h07, 0);
    vadd(13, LDI, 16); vadd(13, STR, 1); vadd(13, LDI, 30); vadd(13, MST, 1); vadd(13, LDI, 0); vadd(13, MLD, 1);
    vadd(13, SHL, 0); vend(13, 3, 36, 11, 8'h1E, 8'h3C); tv[13].nst = 3; tv[13].st[2] = 0;
    vadd(14, LDI, 31); vadd(14, SHL, 0); vadd(14, SHL, 0); vadd(14, SHL, 0); vadd(14, STR, 7); vadd(14, ADD, 7);
    vadd(14, ADC, 7); vend(14, 2, 28, 11, 8'hE9, 1);

    // done rises on the 10th edge after reset release for a 5-instruction program
    clear_imem();
    imem[0] = enc(LDI, 5); imem[1] = enc(STR, 2); imem[2] = enc(LDI, 3); imem[3] = enc(ADD, 2);
    cur_gen++;
    run_dut(1, cyc, fpc);
    check("halt_cycles", cyc, 10);
    check("halt_pc", fpc, 4);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 && err === 1'b0 && pc === 16'd4) cnt++;
    end
    check("halt_frozen", cnt, 5);

    for (int v = 0; v < 15; v++) begin
      clear_imem();
      for (int i = 0; i < tv[v].len; i++) imem[i] = tv[v].prog[i];
      cur_gen++;
      mem_wr_en = 1'b1;
      sb = q_st_addr.size();
      run_dut(tv[v].d, cyc, fpc);
      check($sformatf("v%0d_cycles", v), cyc, tv[v].cyc);
      check($sformatf("v%0d_pc", v), fpc, tv[v].fpc);
      ng = q_st_addr.size() - sb;
      check($sformatf("v%0d_nstores", v), ng, tv[v].nst);
      for (int j = 0; j < tv[v].nst && j < ng; j++)
        check($sformatf("v%0d_store%0d", v, j), q_st_data[sb + j], tv[v].st[j]);
      check($sformatf("v%0d_err", v), err, 0);
    end

    // MST with a 3-cycle ack, then MLD returning 0x55 from the responder
    clear_imem();
    imem[0] = enc(LDI, 2);  imem[1] = enc(STR, 3); imem[2] = enc(LDI, 16); imem[3] = enc(STR, 1);
    imem[4] = enc(LDI, 21); imem[5] = enc(SHL, 0); imem[6] = enc(SHL, 0);  imem[7] = enc(SHL, 0);
    imem[8] = enc(ADD, 3);  imem[9] = enc(MST, 1); imem[10] = enc(MLD, 1); imem[11] = enc(MST, 15);
    cur_gen++;
    mem_wr_en = 1'b0;
    dmem[8'h10] = 8'h55;
    sb = q_st_addr.size();
    lb = q_len.size();
    run_dut(3, cyc, fpc);
    check("mst_done", done, 1);
    check("mst_ntrans", q_len.size() - lb, 3);
    if (q_len.size() >= lb + 2) begin
      check("mst_req_cycles", q_len[lb], 3);
      check("mst_stable", q_stable[lb], 1);
      check("mld_req_cycles", q_len[lb + 1], 3);
    end
    check("mst_nstores", q_st_addr.size() - sb, 2);
    if (q_st_addr.size() >= sb + 2) begin
      check("mst_addr", q_st_addr[sb], 8'h10);
      check("mst_wdata", q_st_data[sb], 8'hAA);
      check("mld_result", q_st_data[sb + 1], 8'h55);
    end
    mem_wr_en = 1'b1;
    dmem[8'h10] = 8'h00;

    // Reset values, taken right after a run that left dm_we/dm_wdata non-zero
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rst_pc", pc, 0);
    check("rst_dm_req", dm_req, 0);
    check("rst_dm_we", dm_we, 0);
    check("rst_dm_addr", dm_addr, 0);
    check("rst_dm_wdata", dm_wdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);

    // JMP 0 is a self-loop
    clear_imem();
    imem[0] = enc(LDI, 1); imem[1] = enc(JMP, 0);
    @(negedge clk) reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("jmp0_pc", pc, 1);
    check("jmp0_done", done, 0);

    for (int p = 0; p < 40; p++) begin
      int d;
      clear_imem();
      for (int i = 0; i < 16; i++) begin
        int k;
        k = int'($urandom_range(0, 13));
        imem[i] = (k >= BRZ) ? enc(k, int'($urandom_range(1, 3))) : enc(k, int'($urandom_range(0, 31)));
      end
      imem[16] = enc(MST, 15); imem[17] = enc(LDI, 0); imem[18] = enc(ADC, 14); imem[19] = enc(MST, 15);
      for (int i = 0; i < 256; i++) begin dmem[i] = 8'($urandom); mdm[i] = dmem[i]; end
      cur_gen++;
      d = int'($urandom_range(1, 4));
      model(d, ecyc, efpc);
      sb = q_st_addr.size();
      lb = q_len.size();
      run_dut(d, cyc, fpc);
      check($sformatf("rnd%0d_cycles", p), cyc, ecyc);
      check($sformatf("rnd%0d_pc", p), fpc, efpc);
      ng = q_st_addr.size() - sb;
      check($sformatf("rnd%0d_nstores", p), ng, e_addr.size());
      for (int j = 0; j < ng && j < e_addr.size(); j++) begin
        check($sformatf("rnd%0d_st%0d_addr", p, j), q_st_addr[sb + j], e_addr[j]);
        check($sformatf("rnd%0d_st%0d_data", p, j), q_st_data[sb + j], e_data[j]);
      end
      allst = 1'b1;
      for (int j = lb; j < q_len.size(); j++) begin
        if (!q_stable[j] || q_len[j] != d) allst = 1'b0;
      end
      check($sformatf("rnd%0d_req_shape", p), allst, 1);
    end

    // Reset in the middle of an unacknowledged MLD; ack held through reset and FETCH
    clear_imem();
    imem[0] = enc(MLD, 0);
    ack_delay = 0;
    force_ack = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("mid_exec_req", dm_req, 0);
    @(posedge clk); #1;
    check("mid_mem_req", dm_req, 1);
    @(posedge clk); #1;
    #1 force_ack = 1'b1;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_req", dm_req, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("late_ack_exec_req", dm_req, 0);
    #1 force_ack = 1'b0;
    @(posedge clk); #1;
    check("late_ack_mem_req", dm_req, 1);
    check("late_ack_pc", pc, 0);

    cnt = 1;
    while (cnt < 150) begin
      @(posedge clk); #1;
      if (dm_req !== 1'b1) break;
      cnt++;
    end
`ifdef ACC_CORE_MC_TIMEOUT_EN
    check("tout_req_cycles", cnt, 16);
    check("tout_req", dm_req, 0);
    check("tout_err", err, 1);
    check("tout_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("tout_err_hold", err, 1);
`else
    check("wait_req_cycles", cnt, 150);
    check("wait_req", dm_req, 1);
    check("wait_err", err, 0);
    check("wait_done", done, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
